// File: rtl/fill_pkg.sv
// fill_pkg: shared state encoding and sizing constants for the FIFO fill controller
package fill_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, SHIFT, DONE} fill_state_t;
  localparam int NUM_ROWS = 9;
  localparam int BYTES_PER_WORD = 8;
  localparam int DATA_WIDTH = 8;
  localparam int WORD_WIDTH = DATA_WIDTH * BYTES_PER_WORD;
  localparam int ROW_B = 0;
  localparam int ROW_A_BASE = 1;
endpackage

// File: rtl/word_serializer.sv
// word_serializer: splits a loaded word into MSB-first bytes, advancing only when the target FIFO accepts
module word_serializer
  import fill_pkg::*;
#(
  parameter int DATA_WIDTH = fill_pkg::DATA_WIDTH,
  parameter int BYTES_PER_WORD = fill_pkg::BYTES_PER_WORD
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word,
  input  logic                               en,
  input  logic                               full,
  output logic [DATA_WIDTH-1:0]              data,
  output logic                               wr,
  output logic                               last_byte
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] sr;
  logic [CW-1:0] cnt;
  assign data = sr[DATA_WIDTH*BYTES_PER_WORD-1 -: DATA_WIDTH];
  assign wr = en & ~full;
  assign last_byte = wr & (cnt == CW'(BYTES_PER_WORD - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
    end else if (load) begin
      sr <= word;
      cnt <= '0;
    end else if (wr) begin
      sr <= sr << DATA_WIDTH;
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: fetches NUM_ROWS words over Avalon-MM and streams their bytes into per-row FIFOs
module fifo_fill_ctrl #(
  parameter int DATA_WIDTH = fill_pkg::DATA_WIDTH,
  parameter int BYTES_PER_WORD = fill_pkg::BYTES_PER_WORD,
  parameter int NUM_ROWS = fill_pkg::NUM_ROWS,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [ADDR_WIDTH-1:0]                address,
  output logic                                 read,
  input  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] readdata,
  input  logic                                 readdatavalid,
  input  logic                                 waitrequest,
  output logic [DATA_WIDTH-1:0]                fifo_data,
  output logic [NUM_ROWS-1:0]                  fifo_wrreq,
  input  logic [NUM_ROWS-1:0]                  fifo_wrfull
);
  import fill_pkg::*;
  localparam int RW = $clog2(NUM_ROWS);
  fill_state_t state, state_n;
  logic [RW-1:0] row;
  logic [ADDR_WIDTH-1:0] base;
  logic wr, last_byte, last_row;
  assign last_row = row == RW'(NUM_ROWS - 1);
  assign fifo_wrreq = wr ? (NUM_ROWS'(1) << row) : '0;
  word_serializer #(.DATA_WIDTH(DATA_WIDTH), .BYTES_PER_WORD(BYTES_PER_WORD)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(state == WAIT_DATA && readdatavalid),
    .word(readdata),
    .en(state == SHIFT),
    .full(fifo_wrfull[row]),
    .data(fifo_data),
    .wr(wr),
    .last_byte(last_byte)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = start ? REQ : IDLE;
      REQ:       state_n = waitrequest ? REQ : WAIT_DATA;
      WAIT_DATA: state_n = readdatavalid ? SHIFT : WAIT_DATA;
      SHIFT:     state_n = last_byte ? (last_row ? DONE : REQ) : SHIFT;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      base <= '0;
      address <= '0;
      read <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (readdatavalid && state != WAIT_DATA) err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          base <= base_addr;
          address <= base_addr;
          row <= RW'(ROW_B);
          read <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          err <= 1'b0;
        end
        REQ: if (!waitrequest) read <= 1'b0;
        SHIFT: if (last_byte) begin
          if (last_row) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            row <= row + RW'(1);
            address <= base + ADDR_WIDTH'(row) + ADDR_WIDTH'(1);
            read <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// tb_fifo_fill_ctrl: scoreboard bench with an Avalon memory model, stall/full/spurious-data injection
module tb_fifo_fill_ctrl;
  logic clk = 0, rst, start;
  logic [31:0] base_addr, address;
  logic busy, done, err, read, readdatavalid, waitrequest;
  logic [63:0] readdata;
  logic [7:0] fifo_data;
  logic [8:0] fifo_wrreq, fifo_wrfull;
  typedef struct { int row; logic [7:0] data; } wr_t;
  wr_t exp_q[$];
  logic [31:0] addr_q[$];
  int checks = 0, errors = 0, cyc = 0, last_wr = 0, acc = 0, a13 = 0, rises = 0;
  logic stall_en = 0, full_en = 0, inj_en = 0, inj_done;
  int stall_left, f4cnt, full_left;

  fifo_fill_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done), .err(err),
    .address(address), .read(read), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_wrfull(fifo_wrfull)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem(input logic [31:0] a);
    return 64'h0102030405060708 + 64'(a - 32'h10);
  endfunction

  assign waitrequest = stall_en && read && address == 32'h13 && stall_left != 0;
  assign fifo_wrfull = {4'b0, full_left != 0, 4'b0};

  always @(posedge clk) begin
    readdatavalid <= 1'b0;
    if (read && !waitrequest) begin
      readdatavalid <= 1'b1;
      readdata <= mem(address);
    end
    if (!inj_en) inj_done <= 1'b0;
    else if (!inj_done && fifo_wrreq[2]) begin
      readdatavalid <= 1'b1;
      readdata <= 64'hDEADBEEFCAFEF00D;
      inj_done <= 1'b1;
    end
    if (!stall_en) stall_left <= 5;
    else if (waitrequest) stall_left <= stall_left - 1;
    if (!full_en) begin
      f4cnt <= 0;
      full_left <= 0;
    end else begin
      if (fifo_wrreq[4]) f4cnt <= f4cnt + 1;
      if (fifo_wrreq[4] && f4cnt == 2) full_left <= 3;
      else if (full_left != 0) full_left <= full_left - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    wr_t e;
    logic done_q = 0;
    forever begin
      @(negedge clk);
      if (fifo_wrreq != 0) begin
        if (exp_q.size() == 0) chk("write_with_empty_q", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("wr_onehot", fifo_wrreq, 64'(9'b1 << e.row));
          chk("wr_data", fifo_data, e.data);
          if (exp_q.size() == 0) last_wr = cyc;
        end
      end
      if (full_en && fifo_wrfull[4]) chk("wrreq4_stall", fifo_wrreq[4], 0);
      if (read && !waitrequest) begin
        acc++;
        if (addr_q.size() == 0) chk("read_with_empty_q", addr_q.size(), 1);
        else chk("read_addr", address, addr_q.pop_front());
      end
      if (read && address == 32'h13) a13++;
      if (done && !done_q) begin
        rises++;
        chk("done_latency", cyc, last_wr + 1);
      end
      done_q = done;
    end
  endtask

  task automatic do_start(input logic [31:0] b, input bit push);
    logic [63:0] w;
    @(negedge clk);
    start = 1;
    base_addr = b;
    if (push) for (int k = 0; k < 9; k++) begin
      w = mem(b + k);
      addr_q.push_back(b + k);
      for (int j = 0; j < 8; j++) exp_q.push_back('{k, w[63-8*j -: 8]});
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    chk("done_timeout", done, 1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_wrreq"}, fifo_wrreq, 0);
    chk({tag, "_data"}, fifo_data, 0);
  endtask

  initial begin
    int a0, c0, r0;
    rst = 1;
    start = 0;
    base_addr = 0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 0;
    // waitrequest stall on row 3, FIFO 4 full after byte 2, start pulsed while busy
    stall_en = 1;
    full_en = 1;
    a0 = a13; c0 = acc; r0 = rises;
    do_start(32'h10, 1);
    repeat (20) @(negedge clk);
    chk("busy_mid", busy, 1);
    do_start(32'h40, 0);
    wait_done();
    chk("fillA_err", err, 0);
    chk("fillA_reads", acc - c0, 9);
    chk("fillA_row3_cycles", a13 - a0, 6);
    repeat (3) @(negedge clk);
    chk("done_held", done, 1);
    chk("busy_after_done", busy, 0);
    chk("fillA_done_rises", rises - r0, 1);
    stall_en = 0;
    full_en = 0;
    // spurious readdatavalid during SHIFT
    inj_en = 1;
    do_start(32'h10, 1);
    wait_done();
    chk("err_sticky", err, 1);
    inj_en = 0;
    // err cleared on start, then reset mid-SHIFT on row 5
    do_start(32'h10, 1);
    chk("err_cleared", err, 0);
    chk("busy_started", busy, 1);
    for (int i = 0; i < 1000 && !fifo_wrreq[5]; i++) @(negedge clk);
    chk("row5_reached", fifo_wrreq[5], 1);
    rst = 1;
    @(negedge clk);
    chk_idle("midrst");
    exp_q.delete();
    addr_q.delete();
    rst = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_read", read, 0);
    chk("post_rst_wrreq", fifo_wrreq, 0);
    // fresh fill from a new base
    do_start(32'h20, 1);
    wait_done();
    chk("fillD_err", err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
